// File: rtl/vc_flit_buffer.sv
// Multi-VC flit buffer: per-VC registered FIFOs and a round-robin wormhole-locked output arbiter.
// Optional per-VC packet counters are built when VC_FLIT_BUFFER_STATS_EN is defined.

module vc_flit_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr,
    input  logic [W-1:0] din,
    input  logic         rd,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wp, rp;
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr && !full)  wp <= wp + (AW+1)'(1);
            if (rd && !empty) rp <= rp + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr && !full) mem[wp[AW-1:0]] <= din;
    end

    // The extra pointer bit tells a full ring from an empty one.
    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout  = mem[rp[AW-1:0]];
endmodule

module vc_flit_buffer #(
    parameter  int FLIT_WIDTH = 34,
    parameter  int N_VIRT_CHN = 2,
    parameter  int BUFF_DEPTH = 4,
    localparam int VC_W       = (N_VIRT_CHN > 1) ? $clog2(N_VIRT_CHN) : 1
) (
    input  logic                    clk_noc,
    input  logic                    arst_noc,
    input  logic                    bypass_i,
    input  logic                    in_valid_i,
    input  logic [FLIT_WIDTH-1:0]   in_data_i,
    input  logic [VC_W-1:0]         in_vc_i,
    input  logic [1:0]              in_type_i,
    output logic [N_VIRT_CHN-1:0]   in_ready_o,
    output logic                    out_valid_o,
    output logic [FLIT_WIDTH-1:0]   out_data_o,
    output logic [VC_W-1:0]         out_vc_o,
    output logic [1:0]              out_type_o,
    input  logic                    out_ready_i,
    output logic [N_VIRT_CHN-1:0]   vc_empty_o,
    output logic [N_VIRT_CHN-1:0]   vc_full_o,
    output logic [N_VIRT_CHN*16-1:0] pkt_cnt_o
);
    typedef struct packed {
        logic [1:0]            typ;
        logic [FLIT_WIDTH-1:0] data;
    } flit_t;

    flit_t                  in_flit;
    flit_t [N_VIRT_CHN-1:0] head;
    logic  [N_VIRT_CHN-1:0] wr, rd, empty, full;
    logic                   lock, stall, any_vld, hs;
    logic  [VC_W-1:0]       lock_vc, rr_ptr, stall_vc, grant, scan;

    assign in_flit = '{typ: in_type_i, data: in_data_i};

    // Out-of-range VC indices match no lane, so such flits are dropped.
    for (genvar v = 0; v < N_VIRT_CHN; v++) begin : g_vc
        assign wr[v] = in_valid_i && !bypass_i && !arst_noc && (in_vc_i == VC_W'(v)) && !full[v];
        assign rd[v] = hs && (grant == VC_W'(v));
        vc_flit_fifo #(.W($bits(flit_t)), .DEPTH(BUFF_DEPTH)) u_fifo (
            .clk  (clk_noc),
            .rst  (arst_noc),
            .wr   (wr[v]),
            .din  (in_flit),
            .rd   (rd[v]),
            .dout (head[v]),
            .empty(empty[v]),
            .full (full[v])
        );
    end

    // Stalled offers keep their VC so a newly filled lower VC cannot steal the slot.
    always_comb begin
        grant   = rr_ptr;
        any_vld = 1'b0;
        scan    = '0;
        if (lock) begin
            grant   = lock_vc;
            any_vld = !empty[lock_vc];
        end else if (stall) begin
            grant   = stall_vc;
            any_vld = 1'b1;
        end else begin
            for (int i = N_VIRT_CHN-1; i >= 0; i--) begin
                scan = VC_W'((int'(rr_ptr) + i) % N_VIRT_CHN);
                if (!empty[scan]) begin
                    grant   = scan;
                    any_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        out_valid_o = 1'b0;
        out_data_o  = head[grant].data;
        out_vc_o    = grant;
        out_type_o  = head[grant].typ;
        in_ready_o  = '0;
        if (!arst_noc) begin
            if (bypass_i) begin
                out_valid_o = in_valid_i;
                out_data_o  = in_data_i;
                out_vc_o    = in_vc_i;
                out_type_o  = in_type_i;
                in_ready_o  = {N_VIRT_CHN{out_ready_i}};
            end else begin
                out_valid_o = any_vld;
                in_ready_o  = ~full;
            end
        end
    end

    assign hs         = out_valid_o && out_ready_i && !bypass_i;
    assign vc_empty_o = empty;
    assign vc_full_o  = full;

    always_ff @(posedge clk_noc) begin
        if (arst_noc) begin
            lock     <= 1'b0;
            lock_vc  <= '0;
            rr_ptr   <= '0;
            stall    <= 1'b0;
            stall_vc <= '0;
        end else begin
            stall    <= !bypass_i && out_valid_o && !out_ready_i;
            stall_vc <= grant;
            if (hs) begin
                case (out_type_o)
                    2'b00: begin
                        lock    <= 1'b1;
                        lock_vc <= grant;
                    end
                    2'b10, 2'b11: begin
                        lock   <= 1'b0;
                        rr_ptr <= (grant == VC_W'(N_VIRT_CHN-1)) ? '0 : grant + VC_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef VC_FLIT_BUFFER_STATS_EN
    logic [N_VIRT_CHN-1:0][15:0] cnt;

    always_ff @(posedge clk_noc) begin
        if (arst_noc) begin
            cnt <= '0;
        end else begin
            for (int v = 0; v < N_VIRT_CHN; v++)
                if (rd[v] && out_type_o[1] && cnt[v] != 16'hFFFF) cnt[v] <= cnt[v] + 16'd1;
        end
    end

    assign pkt_cnt_o = cnt;
`else
    assign pkt_cnt_o = '0;
`endif
endmodule

// File: tb/tb_vc_flit_buffer.sv
// Random and directed traffic against a queue-based model of the VC flit buffer.
module tb_vc_flit_buffer;
    localparam int FW = 34;
    localparam int N  = 2;
    localparam int D  = 4;
    localparam int VW = 1;

    logic           clk_noc = 1'b0;
    logic           arst_noc = 1'b1, bypass_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0;
    logic [FW-1:0]  in_data_i = '0;
    logic [VW-1:0]  in_vc_i = '0;
    logic [1:0]     in_type_i = '0;
    logic [N-1:0]   in_ready_o, vc_empty_o, vc_full_o;
    logic           out_valid_o;
    logic [FW-1:0]  out_data_o;
    logic [VW-1:0]  out_vc_o;
    logic [1:0]     out_type_o;
    logic [N*16-1:0] pkt_cnt_o;

    vc_flit_buffer #(.FLIT_WIDTH(FW), .N_VIRT_CHN(N), .BUFF_DEPTH(D)) dut (
        .clk_noc(clk_noc), .arst_noc(arst_noc), .bypass_i(bypass_i),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_vc_i(in_vc_i), .in_type_i(in_type_i),
        .in_ready_o(in_ready_o), .out_valid_o(out_valid_o), .out_data_o(out_data_o),
        .out_vc_o(out_vc_o), .out_type_o(out_type_o), .out_ready_i(out_ready_i),
        .vc_empty_o(vc_empty_o), .vc_full_o(vc_full_o), .pkt_cnt_o(pkt_cnt_o)
    );

    always #5 clk_noc = ~clk_noc;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Model: one queue of {type,data} per VC plus packet-level arbitration state.
    logic [FW+1:0] q[N][$];
    bit m_lock, m_hold;
    int m_lock_vc, m_rr, m_hold_vc;
    int m_cnt[N];

    task automatic model_reset();
        for (int v = 0; v < N; v++) begin
            q[v].delete();
            m_cnt[v] = 0;
        end
        m_lock = 0; m_hold = 0; m_rr = 0; m_lock_vc = 0; m_hold_vc = 0;
    endtask

    task automatic cycle(input bit rst, input bit byp, input bit iv, input logic [FW-1:0] d,
                         input int vc, input logic [1:0] t, input bit rdy);
        logic [N-1:0]    e_ready, e_empty, e_full;
        logic [N*16-1:0] e_cnt;
        bit              ev, wr_ok;
        int              g;
        logic [FW+1:0]   ef;
        @(negedge clk_noc);
        arst_noc = rst; bypass_i = byp; in_valid_i = iv; in_data_i = d;
        in_vc_i = vc[VW-1:0]; in_type_i = t; out_ready_i = rdy;
        #1;
        g = 0; ev = 0; ef = '0;
        if (!rst && byp) begin
            ev = iv; g = vc; ef = {t, d};
        end else if (!rst) begin
            if (m_lock) begin
                g = m_lock_vc; ev = q[g].size() > 0;
            end else if (m_hold) begin
                g = m_hold_vc; ev = 1;
            end else begin
                for (int i = 0; i < N && !ev; i++) begin
                    g = (m_rr + i) % N;
                    ev = q[g].size() > 0;
                end
            end
            if (ev) ef = q[g][0];
        end
        for (int v = 0; v < N; v++) begin
            e_ready[v] = rst ? 1'b0 : byp ? rdy : (q[v].size() < D);
            e_empty[v] = q[v].size() == 0;
            e_full[v]  = q[v].size() == D;
`ifdef VC_FLIT_BUFFER_STATS_EN
            e_cnt[v*16 +: 16] = 16'(m_cnt[v]);
`else
            e_cnt[v*16 +: 16] = 16'h0;
`endif
        end
        chk("in_ready", in_ready_o, e_ready);
        chk("out_valid", out_valid_o, ev);
        if (ev) begin
            chk("out_data", out_data_o, ef[FW-1:0]);
            chk("out_type", out_type_o, ef[FW+1:FW]);
            chk("out_vc", out_vc_o, g);
        end
        if (!rst) begin
            chk("vc_empty", vc_empty_o, e_empty);
            chk("vc_full", vc_full_o, e_full);
            chk("pkt_cnt", pkt_cnt_o, e_cnt);
        end
        if (rst) begin
            model_reset();
        end else if (byp) begin
            m_hold = 0;
        end else begin
            wr_ok = iv && vc < N && q[vc].size() < D;
            if (ev && rdy) begin
                void'(q[g].pop_front());
                case (ef[FW+1:FW])
                    2'b00: begin m_lock = 1; m_lock_vc = g; end
                    2'b10, 2'b11: begin
                        m_lock = 0; m_rr = (g + 1) % N;
                        if (m_cnt[g] < 65535) m_cnt[g]++;
                    end
                    default: ;
                endcase
            end
            m_hold = ev && !rdy; m_hold_vc = g;
            if (wr_ok) q[vc].push_back({t, d});
        end
    endtask

    function automatic logic [1:0] rnd_type();
        int r = $urandom_range(0, 9);
        return (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 8) ? 2'b10 : 2'b11;
    endfunction

    function automatic logic [FW-1:0] rnd_data();
        return FW'({$urandom, $urandom});
    endfunction

    initial begin
        model_reset();
        // Reset held with a valid flit present: nothing may be written.
        cycle(1, 0, 1, 34'h1, 0, 2'b11, 1);
        cycle(1, 0, 1, 34'h2, 1, 2'b11, 1);
        cycle(0, 0, 0, 34'h0, 0, 2'b00, 0);
        cycle(0, 0, 0, 34'h0, 0, 2'b00, 1);

        // Fill VC0 past depth with the output stalled, then drain.
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 34'h100 + FW'(i), 0, 2'b01, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 34'h0, 0, 2'b00, 1);

        // VC0 H,B,T and VC1 H+T queued together.
        cycle(1, 0, 0, 34'h0, 0, 2'b00, 0);
        cycle(0, 0, 1, 34'h200, 1, 2'b11, 0);
        cycle(0, 0, 1, 34'h201, 0, 2'b00, 0);
        cycle(0, 0, 1, 34'h202, 0, 2'b01, 0);
        cycle(0, 0, 1, 34'h203, 0, 2'b10, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 34'h0, 0, 2'b00, 1);

        // Lock holds VC0 while its FIFO is empty and VC1 is waiting.
        cycle(1, 0, 0, 34'h0, 0, 2'b00, 0);
        cycle(0, 0, 1, 34'h300, 0, 2'b00, 1);
        cycle(0, 0, 1, 34'h301, 1, 2'b11, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 34'h0, 0, 2'b00, 1);
        cycle(0, 0, 1, 34'h302, 0, 2'b01, 1);
        cycle(0, 0, 1, 34'h303, 0, 2'b10, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 34'h0, 0, 2'b00, 1);

        // Three single-flit packets on VC1.
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 34'h400 + FW'(i), 1, 2'b11, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 34'h0, 0, 2'b00, 1);

        // Bypass from a clean state.
        cycle(1, 0, 0, 34'h0, 0, 2'b00, 0);
        cycle(0, 1, 1, 34'h2A, 0, 2'b11, 1);
        for (int i = 0; i < 40; i++)
            cycle(0, 1, $urandom_range(0, 1), rnd_data(), $urandom_range(0, N-1), rnd_type(),
                  $urandom_range(0, 1));

        // Random buffered traffic, with one mid-stream reset.
        for (int i = 0; i < 1500; i++) begin
            cycle(i == 700, 0, $urandom_range(0, 2) != 0, rnd_data(), $urandom_range(0, N-1),
                  rnd_type(), $urandom_range(0, 9) < 6);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/vc_flit_buffer.md
Name: vc_flit_buffer

Overview:
- Single-clock, multi-virtual-channel flit buffer that sits between the packet generator and the NoC router input inside the NoC clock domain.
- Each VC has its own registered FIFO of parametrised depth.
- A round-robin output arbiter with wormhole lock serialises the VCs onto one flit channel; a lock is held from head flit to tail flit.
- A runtime bypass mode forwards flits combinationally, for configurations with no buffering.

Parameters:
FLIT_WIDTH, 34, payload bits per flit
N_VIRT_CHN, 2, number of virtual channels (>=1)
BUFF_DEPTH, 4, flits per VC FIFO (power of two, >=2)
VC_W, $clog2(N_VIRT_CHN) min 1, VC index width (derived localparam)

Ports:
clk_noc  in  1  clock
arst_noc  in  1  reset, synchronous, active-high
bypass_i  in  1  1 = combinational pass-through
in_valid_i  in  1  input flit valid
in_data_i  in  FLIT_WIDTH  input flit payload
in_vc_i  in  VC_W  target VC of input flit
in_type_i  in  2  00 head, 01 body, 10 tail, 11 head+tail (single-flit pkt)
in_ready_o  out  N_VIRT_CHN  per-VC space available
out_valid_o  out  1  output flit valid
out_data_o  out  FLIT_WIDTH  output payload
out_vc_o  out  VC_W  VC of output flit
out_type_o  out  2  type of output flit
out_ready_i  in  1  downstream accepts
vc_empty_o  out  N_VIRT_CHN  per-VC FIFO empty
vc_full_o  out  N_VIRT_CHN  per-VC FIFO full
pkt_cnt_o  out  N_VIRT_CHN*16  per-VC packet counters (optional feature)

Behaviour:
- Reset (arst_noc=1 at a clk_noc edge):
  - All FIFO pointers cleared; lock flag cleared; round-robin pointer set to VC0.
  - While arst_noc is high: in_ready_o=0 and out_valid_o=0.
  - After reset: vc_empty_o=all 1, vc_full_o=0, in_ready_o=all 1.
  - Reset mid-packet discards all buffered flits and the lock.
- Input handshake:
  - A flit is written to FIFO[in_vc_i] when in_valid_i && in_ready_o[in_vc_i] && !bypass_i.
  - in_ready_o[v] = !full[v]. No write-through on full: a read in the same cycle does not free the slot until the next cycle.
  - in_vc_i >= N_VIRT_CHN: flit dropped, nothing written.
- FIFO: {type, data} stored; pointers are VC-local and wrap modulo BUFF_DEPTH, with an extra wrap bit to distinguish full from empty. Simultaneous read and write on a non-empty, non-full FIFO keeps occupancy constant.
- Latency: a flit written at edge t is visible on out_* in the cycle after t (one cycle minimum). There is no pass-through when the FIFO is empty.
- Arbitration, when unlocked:
  - Grant goes to the first non-empty VC, searching from rr_ptr upward with wrap. The grant is combinational.
  - out_valid_o=1 if any VC is non-empty; out_* = head of the granted FIFO.
- Lock:
  - A head (00) flit that completes a handshake sets lock=1 and lock_vc=granted VC.
  - While locked, only lock_vc is eligible. If that FIFO is empty, out_valid_o=0 even if other VCs hold flits.
  - A tail (10) flit, or a head+tail (11) flit, that completes a handshake clears lock and sets rr_ptr=(granted VC+1) mod N_VIRT_CHN.
  - A body flit while unlocked is forwarded and does not change the lock; type ordering is the producer's responsibility.
- Output stability: once out_valid_o=1 with out_ready_i=0, out_data_o, out_vc_o and out_type_o are held until the handshake.
  - While locked this holds trivially.
  - While unlocked, the arbiter state (grant) is frozen while out_valid_o && !out_ready_i.
- Bypass (bypass_i=1):
  - out_valid_o=in_valid_i, out_data/vc/type = in_*, in_ready_o=all out_ready_i.
  - FIFOs are neither written nor read; arbiter and lock state are retained.
  - Buffered flits are emitted after bypass_i falls.
  - Toggling bypass_i is legal only when all VCs are empty and unlocked; otherwise behaviour is undefined.

Optional Feature:
- Macro: VC_FLIT_BUFFER_STATS_EN.
- Defined:
  - pkt_cnt_o[v*16+:16] increments on each output handshake of a tail or head+tail flit on VC v, in buffered mode only.
  - Counters saturate at 16'hFFFF and clear on reset.
- Undefined: pkt_cnt_o is tied to 0 and no counter flops are inferred.

Test Plan:
- Reset then idle: in_ready_o=2'b11, vc_empty_o=2'b11, out_valid_o=0; hold arst_noc high with in_valid_i=1 -> nothing written.
- Write 4 flits to VC0 with out_ready_i=0, BUFF_DEPTH=4 -> vc_full_o[0]=1, in_ready_o[0]=0, in_ready_o[1]=1; 5th write dropped; then drain -> data emerges in order, one per cycle.
- VC0 packet H,B,T and VC1 packet H+T queued together, rr_ptr=0 -> output VC0 H,B,T then VC1 H+T; rr_ptr ends at 0.
- VC0 head sent, VC0 FIFO then empty, VC1 holds flits -> out_valid_o=0 until VC0 body arrives; no VC1 flit is interleaved.
- bypass_i=1, in_valid_i=1, data=0x2A, out_ready_i=1 -> out_data_o=0x2A in the same cycle; vc_empty_o stays all 1.
- With VC_FLIT_BUFFER_STATS_EN: three single-flit packets on VC1 -> pkt_cnt_o[31:16]=3, pkt_cnt_o[15:0]=0.
